// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared sequencer state encoding and default sizing for the UART transmit scheduler
package uart_sched_pkg;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_AW = 3;
    localparam int DEF_START_TO = 4;
    localparam int DEF_GAP = 0;
    typedef enum logic [2:0] {ST_IDLE, ST_LAUNCH, ST_WAIT_START, ST_WAIT_DONE, ST_GAP} state_t;
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester, flush, uart handshake and fifo status signals of the transmit scheduler
interface uart_tx_sched_if import uart_sched_pkg::*; #(parameter int AW = DEF_AW);
    logic a_valid;
    logic [7:0] a_data;
    logic a_ready;
    logic b_valid;
    logic [7:0] b_data;
    logic b_ready;
    logic flush;
    logic uart_busy;
    logic uart_transmit;
    logic [7:0] uart_tx_byte;
    logic [AW:0] fifo_count;
    logic fifo_full;
    logic fifo_empty;
    logic start_err;
    modport master (
        output a_valid, a_data, b_valid, b_data, flush, uart_busy,
        input a_ready, b_ready, uart_transmit, uart_tx_byte, fifo_count, fifo_full, fifo_empty, start_err
    );
    modport slave (
        input a_valid, a_data, b_valid, b_data, flush, uart_busy,
        output a_ready, b_ready, uart_transmit, uart_tx_byte, fifo_count, fifo_full, fifo_empty, start_err
    );
endinterface

// File: rtl/uart_tx_sched_fifo.sv
// sched_fifo: synchronous byte FIFO with flush; flush overrides push and pop, pointers wrap modulo DEPTH
module sched_fifo import uart_sched_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW = DEF_AW
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [AW:0] count,
    output logic full,
    output logic empty
);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push & ~full & ~flush;
    assign do_pop = pop & ~empty & ~flush;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter of two byte sources into a FIFO, sequencing one-byte-at-a-time uart launches
module uart_tx_sched import uart_sched_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW = DEF_AW,
    parameter int START_TO = DEF_START_TO,
    parameter int GAP = DEF_GAP
) (
    input logic clk,
    input logic reset_n,
    uart_tx_sched_if.slave bus
);
    state_t state, state_d;
    logic pref_b, a_push, b_push, push, pop, timeout, gap_done;
    logic [3:0] cnt;
    logic [7:0] din, head;
    assign bus.a_ready = ~bus.fifo_full & ~bus.flush & (~bus.b_valid | ~pref_b);
    assign bus.b_ready = ~bus.fifo_full & ~bus.flush & (~bus.a_valid | pref_b);
    assign a_push = bus.a_valid & bus.a_ready;
    assign b_push = bus.b_valid & bus.b_ready;
    assign push = a_push | b_push;
    assign din = a_push ? bus.a_data : bus.b_data;
    assign pop = state == ST_LAUNCH;
    assign timeout = cnt == 4'(START_TO - 1);
    assign gap_done = cnt == 4'(GAP - 1);
    sched_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .pop(pop),
        .flush(bus.flush),
        .din(din),
        .dout(head),
        .count(bus.fifo_count),
        .full(bus.fifo_full),
        .empty(bus.fifo_empty)
    );
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:       state_d = (~bus.fifo_empty & ~bus.uart_busy & ~bus.flush) ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH:     state_d = ST_WAIT_START;
            ST_WAIT_START: state_d = bus.uart_busy ? ST_WAIT_DONE : timeout ? ST_IDLE : ST_WAIT_START;
            ST_WAIT_DONE:  state_d = bus.uart_busy ? ST_WAIT_DONE : (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:        state_d = gap_done ? ST_IDLE : ST_GAP;
            default:       state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt <= '0;
            pref_b <= 1'b0;
            bus.uart_transmit <= 1'b0;
            bus.uart_tx_byte <= 8'h00;
            bus.start_err <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= (state_d != state) ? 4'd0 : cnt + 4'd1;
            pref_b <= push ? a_push : pref_b;
            bus.uart_transmit <= pop;
            bus.uart_tx_byte <= pop ? head : bus.uart_tx_byte;
            bus.start_err <= bus.flush ? 1'b0 : (state == ST_WAIT_START && !bus.uart_busy && timeout) ? 1'b1 : bus.start_err;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scoreboard bench with a simple uart busy model
module tb_uart_tx_sched;
    localparam int GAP_C = 3;
    localparam int START_TO_C = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic hold_busy = 1'b0;
    logic no_busy = 1'b0;
    int busy_cnt = 0;
    int cyc = 0;
    int pulses = 0;
    int errors = 0;
    int checks = 0;
    logic [7:0] sb [$];
    uart_tx_sched_if #(.AW(3)) bus ();
    uart_tx_sched #(.DEPTH(8), .AW(3), .START_TO(START_TO_C), .GAP(GAP_C)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk)
        if (bus.uart_transmit && !no_busy) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    assign bus.uart_busy = hold_busy | (busy_cnt > 0);
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk)
        if (bus.uart_transmit) begin
            pulses <= pulses + 1;
            check("pulse_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) check("tx_byte_order", bus.uart_tx_byte, sb.pop_front());
        end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push_a(input logic [7:0] d);
        bus.a_valid = 1'b1;
        bus.a_data = d;
        #1;
        check("a_ready_single", bus.a_ready, 1);
        sb.push_back(d);
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
    endtask
    task automatic wait_tx(input string tag);
        int n = 0;
        while (!bus.uart_transmit && n < 60) begin tick(1); n++; end
        check(tag, bus.uart_transmit, 1);
    endtask
    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (bus.uart_busy !== lvl && n < 60) begin tick(1); n++; end
        check(tag, bus.uart_busy, lvl);
    endtask
    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 600) begin tick(1); n++; end
        check(tag, sb.size(), 0);
    endtask
    initial begin
        int p0, x, p, n;
        logic pref_a_m;
        logic [7:0] a_n, b_n;
        bus.a_valid = 0; bus.a_data = 0; bus.b_valid = 0; bus.b_data = 0; bus.flush = 0;
        tick(2);
        check("rst_empty", bus.fifo_empty, 1);
        check("rst_full", bus.fifo_full, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_transmit", bus.uart_transmit, 0);
        check("rst_tx_byte", bus.uart_tx_byte, 8'h00);
        check("rst_start_err", bus.start_err, 0);
        reset_n = 1;
        tick(1);
        push_a(8'h55);
        check("single_count1", bus.fifo_count, 1);
        tick(1);
        check("single_no_early_pulse", bus.uart_transmit, 0);
        tick(1);
        check("single_pulse", bus.uart_transmit, 1);
        check("single_byte", bus.uart_tx_byte, 8'h55);
        check("single_count0", bus.fifo_count, 0);
        tick(1);
        check("single_pulse_one_cycle", bus.uart_transmit, 0);
        tick(25);
        check("single_pulse_total", pulses, 1);
        reset_n = 0;
        tick(1);
        reset_n = 1;
        pref_a_m = 1; a_n = 8'h01; b_n = 8'h81;
        bus.a_valid = 1; bus.b_valid = 1;
        for (int i = 0; i < 6; i++) begin
            bus.a_data = a_n; bus.b_data = b_n;
            #1;
            check("contend_a_ready", bus.a_ready, pref_a_m);
            check("contend_b_ready", bus.b_ready, !pref_a_m);
            sb.push_back(pref_a_m ? a_n : b_n);
            if (pref_a_m) a_n++; else b_n++;
            pref_a_m = !pref_a_m;
            @(posedge clk);
            #1;
        end
        bus.a_valid = 0; bus.b_valid = 0;
        drain("contend_drain");
        tick(30);
        check("contend_empty", bus.fifo_empty, 1);
        hold_busy = 1;
        for (int i = 0; i < 8; i++) push_a(8'h10 + 8'(i));
        p0 = pulses;
        check("full_flag", bus.fifo_full, 1);
        check("full_count", bus.fifo_count, 8);
        bus.a_valid = 1; bus.a_data = 8'h18;
        tick(3);
        #1;
        check("full_blocks_push", bus.a_ready, 0);
        check("full_count_held", bus.fifo_count, 8);
        check("busy_holds_launch", pulses - p0, 0);
        hold_busy = 0;
        n = 0;
        while (!bus.a_ready && n < 20) begin tick(1); #1; n++; end
        check("push_after_pop_count", bus.fifo_count, 7);
        sb.push_back(8'h18);
        @(posedge clk);
        #1;
        bus.a_valid = 0;
        drain("full_drain");
        tick(30);
        check("full_drained_empty", bus.fifo_empty, 1);
        no_busy = 1;
        push_a(8'hAA);
        wait_tx("timeout_pulse");
        tick(START_TO_C - 1);
        check("timeout_not_yet", bus.start_err, 0);
        tick(1);
        check("timeout_err", bus.start_err, 1);
        push_a(8'hBB);
        wait_tx("after_timeout_pulse");
        tick(START_TO_C + 2);
        check("err_sticky", bus.start_err, 1);
        bus.flush = 1;
        #1;
        check("flush_blocks_ready", bus.a_ready, 0);
        tick(1);
        bus.flush = 0;
        check("flush_clears_err", bus.start_err, 0);
        no_busy = 0;
        tick(5);
        for (int i = 0; i < 5; i++) push_a(8'h20 + 8'(i));
        wait_busy(1, "flush_busy_rise");
        bus.flush = 1;
        tick(1);
        bus.flush = 0;
        sb.delete();
        p0 = pulses;
        check("flush_count", bus.fifo_count, 0);
        check("flush_empty", bus.fifo_empty, 1);
        wait_busy(0, "flush_inflight_completes");
        tick(20);
        check("flush_no_more_pulses", pulses - p0, 0);
        for (int i = 0; i < 5; i++) push_a(8'h30 + 8'(i));
        wait_busy(1, "reset_busy_rise");
        reset_n = 0;
        tick(1);
        reset_n = 1;
        sb.delete();
        p0 = pulses;
        check("midrst_count", bus.fifo_count, 0);
        check("midrst_empty", bus.fifo_empty, 1);
        check("midrst_transmit", bus.uart_transmit, 0);
        check("midrst_tx_byte", bus.uart_tx_byte, 8'h00);
        check("midrst_start_err", bus.start_err, 0);
        wait_busy(0, "midrst_busy_fall");
        tick(20);
        check("midrst_no_pulses", pulses - p0, 0);
        bus.a_valid = 1; bus.b_valid = 1; bus.a_data = 8'h40; bus.b_data = 8'hC0;
        #1;
        check("midrst_pref_a", bus.a_ready, 1);
        check("midrst_pref_not_b", bus.b_ready, 0);
        sb.push_back(8'h40);
        tick(1);
        check("pref_moves_b", bus.b_ready, 1);
        check("pref_moves_not_a", bus.a_ready, 0);
        sb.push_back(8'hC0);
        tick(1);
        bus.a_valid = 0; bus.b_valid = 0;
        drain("midrst_drain");
        tick(30);
        push_a(8'h50);
        push_a(8'h51);
        wait_busy(1, "gap_busy_rise");
        wait_busy(0, "gap_busy_fall");
        x = cyc;
        wait_tx("gap_second_pulse");
        p = cyc;
        check("gap_spacing", p - x, 3 + GAP_C);
        drain("gap_drain");
        tick(20);
        check("final_empty", bus.fifo_empty, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Arbitrates two byte requesters (A = CPU IO-write path, B = secondary/debug source) onto the single UART transmitter.
- Buffers accepted bytes in a small FIFO and sequences the UART `transmit` / `tx_byte` / `is_transmitting` handshake, one byte at a time.
- Sits in the UART clock domain, between the cross-domain bus bridges and the uart instance.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, log2(DEPTH).
- START_TO, 4, max cycles after a launch pulse to wait for uart_busy to rise (1..15).
- GAP, 0, idle cycles inserted after each byte completes before the next launch (0..15).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- a_valid  in  1  requester A has a byte.
- a_data  in  8  requester A byte.
- a_ready  out  1  A byte accepted this cycle when a_valid & a_ready.
- b_valid  in  1  requester B has a byte.
- b_data  in  8  requester B byte.
- b_ready  out  1  B byte accepted this cycle when b_valid & b_ready.
- flush  in  1  synchronous FIFO clear.
- uart_busy  in  1  uart is_transmitting.
- uart_transmit  out  1  one-cycle launch pulse to uart.
- uart_tx_byte  out  8  byte to uart; registered, held between launches.
- fifo_count  out  AW+1  entries stored, 0..DEPTH.
- fifo_full  out  1  fifo_count == DEPTH.
- fifo_empty  out  1  fifo_count == 0.
- start_err  out  1  sticky: uart failed to go busy within START_TO.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n.
- Reset (reset_n=0 at an edge):
  - FIFO pointers and count cleared; fifo_empty=1, fifo_full=0.
  - FSM to IDLE; uart_transmit=0; uart_tx_byte=8'h00; start_err=0.
  - Round-robin preference set to A; gap counter and timeout counter cleared.
  - Reset mid-transmission drops the byte in flight silently; the uart is not touched.
- Arbitration (combinational ready):
  - At most one push per cycle.
  - a_ready = ~fifo_full & ~flush & (~b_valid | pref==A).
  - b_ready = ~fifo_full & ~flush & (~a_valid | pref==B).
  - A single valid requester is always granted when not full.
  - After each accepted push, pref moves to the other requester (strict alternation under contention).
  - Full is evaluated before the edge: a pop on a full FIFO does not allow a push in the same cycle.
- FIFO:
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - flush clears pointers/count and start_err; it does not abort the byte already launched to the uart.
  - flush has priority over push and pop.
- Sequencer FSM (registered):
  - IDLE: if ~fifo_empty & ~uart_busy → LAUNCH at next edge.
  - LAUNCH (1 cycle): uart_transmit=1, uart_tx_byte=head, head popped; → WAIT_START.
  - WAIT_START: uart_busy=1 → WAIT_DONE. If START_TO cycles elapse without busy, set start_err → IDLE.
  - WAIT_DONE: uart_busy=0 → GAP if GAP>0, else IDLE.
  - GAP: count GAP cycles → IDLE.
- Latency: a byte pushed into an empty, idle scheduler at edge N gives uart_transmit=1 during the cycle after edge N+2. The byte is already present on uart_tx_byte when the pulse is high.
- uart_busy high in IDLE (external transmission in progress) holds the launch until it falls.

Decomposition:
- Shared package uart_sched_pkg:
  - FSM state encoding constants: IDLE, LAUNCH, WAIT_START, WAIT_DONE, GAP.
  - Default DEPTH / AW / START_TO / GAP values.
- One sub-module, sched_fifo: synchronous DEPTH×8 FIFO with push, pop, flush, count, full, empty; no look-ahead beyond the head register.
- Arbiter and FSM stay in uart_tx_sched.

Test Plan:
- Single byte: A pushes 8'h55 with uart model asserting busy 1 cycle after the pulse, holding 10 cycles → exactly one uart_transmit pulse, 2 edges after acceptance, uart_tx_byte=8'h55; fifo_count 1→0; FSM back in IDLE after busy falls.
- Contention: A and B both valid continuously with A=8'h01.., B=8'h81.. → accepted order 01,81,02,82,...; uart receives the same order; no cycle where both readies are high.
- Full boundary: hold uart_busy=1, push 9 bytes from A → first 8 accepted, fifo_full=1, a_ready=0 for the 9th. Release busy → 8 launches in FIFO order; fifo_empty=1 at the end.
- Timeout: uart model never asserts busy, push 8'hAA → pulse, then start_err=1 after START_TO=4 cycles; next byte still launched. Flush → start_err=0.
- Flush/reset mid-operation: 5 bytes queued, flush during WAIT_DONE → count=0, current byte completes, no further pulses. Repeat with reset_n=0 → outputs at reset values next edge, pref=A.
- GAP=3: two queued bytes → exactly 3 idle cycles between busy falling and the second uart_transmit.
